// File: rtl/rr_mux4_arbiter.sv
// Round-robin owner for a 4:1 source mux with a registered valid/ready beat.
// Optional ARB_LOCK_EN adds a lock input that pins the current owner.
module rr_mux4_arbiter #(
  parameter int WIDTH     = 32,
  parameter int MAX_BEATS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic [WIDTH-1:0] src3,
  input  logic [WIDTH-1:0] src4,
`ifdef ARB_LOCK_EN
  input  logic [3:0]       lock,
`endif
  output logic [1:0]       select,
  output logic [3:0]       gnt,
  output logic [3:0]       ack,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;
  localparam logic [3:0] MAX_CNT = 4'(MAX_BEATS);

  logic [0:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [WIDTH-1:0] src [4];
  assign src[0] = src1;
  assign src[1] = src2;
  assign src[2] = src3;
  assign src[3] = src4;

  // {found, index}: nearest set bit at or after p, wrapping
  function automatic logic [2:0] pick(
    input logic [3:0] r,
    input logic [1:0] p
  );
    logic [1:0] idx;
    pick = 3'b000;
    for (int j = 3; j >= 0; j--) begin
      idx = p + 2'(j);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  logic       busy;
  logic       keep;
  logic [1:0] rot_ptr;
  logic [2:0] win_idle;
  logic [2:0] win_rot;

  assign busy    = (state_q == S_BUSY);
  assign rot_ptr = sel_q + 2'd1;
  assign win_idle = pick(req, ptr_q);
  assign win_rot  = pick(req & ~(4'b0001 << sel_q), rot_ptr);

`ifdef ARB_LOCK_EN
  assign keep = req[sel_q] &&
                ((beat_cnt_q < MAX_CNT) || lock[sel_q]);
`else
  assign keep = req[sel_q] && (beat_cnt_q < MAX_CNT);
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    beat_cnt_d = beat_cnt_q;
    sel_d      = sel_q;
    data_d     = data_q;
    unique case (1'b1)
      !busy: begin
        if (win_idle[2]) begin
          state_d    = S_BUSY;
          sel_d      = win_idle[1:0];
          data_d     = src[win_idle[1:0]];
          beat_cnt_d = 4'd1;
        end
      end
      busy && !out_ready: begin
      end
      busy && out_ready && keep: begin
        data_d = src[sel_q];
        if (beat_cnt_q < MAX_CNT)
          beat_cnt_d = beat_cnt_q + 4'd1;
      end
      busy && out_ready && !keep: begin
        ptr_d = rot_ptr;
        if (win_rot[2]) begin
          sel_d      = win_rot[1:0];
          data_d     = src[win_rot[1:0]];
          beat_cnt_d = 4'd1;
        end else begin
          state_d    = S_IDLE;
          sel_d      = 2'd0;
          beat_cnt_d = 4'd0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      ptr_q      <= 2'd0;
      beat_cnt_q <= 4'd0;
      sel_q      <= 2'd0;
      data_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      beat_cnt_q <= beat_cnt_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
    end
  end

  assign select    = sel_q;
  assign out_valid = busy;
  assign out_data  = data_q;
  assign gnt = busy ? (4'b0001 << sel_q) : 4'b0000;
  assign ack = (busy && out_ready) ? (4'b0001 << sel_q) : 4'b0000;

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: MAX_BEATS=4 and MAX_BEATS=1 instances
// against a queue-free behavioural owner/pointer model.
module tb_rr_mux4_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [31:0] s [4];
  logic        out_ready = 1'b0;

  logic [1:0]  sel_o [2];
  logic [3:0]  gnt_o [2];
  logic [3:0]  ack_o [2];
  logic        val_o [2];
  logic [31:0] dat_o [2];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_mux4_arbiter #(.WIDTH(32), .MAX_BEATS(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .src1(s[0]), .src2(s[1]), .src3(s[2]), .src4(s[3]),
`ifdef ARB_LOCK_EN
    .lock(4'b0000),
`endif
    .select(sel_o[0]), .gnt(gnt_o[0]), .ack(ack_o[0]),
    .out_valid(val_o[0]), .out_ready(out_ready), .out_data(dat_o[0])
  );

  rr_mux4_arbiter #(.WIDTH(32), .MAX_BEATS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .src1(s[0]), .src2(s[1]), .src3(s[2]), .src4(s[3]),
`ifdef ARB_LOCK_EN
    .lock(4'b0000),
`endif
    .select(sel_o[1]), .gnt(gnt_o[1]), .ack(ack_o[1]),
    .out_valid(val_o[1]), .out_ready(out_ready), .out_data(dat_o[1])
  );

  // Model: owner index (-1 idle), priority pointer, beat count, held word
  int          owner [2] = '{-1, -1};
  int          ptr   [2] = '{0, 0};
  int          cnt   [2] = '{0, 0};
  logic [31:0] mdat  [2] = '{32'h0, 32'h0};
  int          maxb  [2] = '{4, 1};

  function automatic int find(input logic [3:0] r, input int p,
                              input int excl);
    for (int j = 0; j < 4; j++) begin
      int i;
      i = (p + j) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        owner[k] = -1; ptr[k] = 0; cnt[k] = 0; mdat[k] = 32'h0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int w;
        if (owner[k] < 0) begin
          w = find(req, ptr[k], -1);
          if (w >= 0) begin
            owner[k] = w; cnt[k] = 1; mdat[k] = s[w];
          end
        end else if (out_ready) begin
          if (req[owner[k]] && cnt[k] < maxb[k]) begin
            cnt[k] = cnt[k] + 1; mdat[k] = s[owner[k]];
          end else begin
            ptr[k] = (owner[k] + 1) % 4;
            w = find(req, ptr[k], owner[k]);
            if (w >= 0) begin
              owner[k] = w; cnt[k] = 1; mdat[k] = s[w];
            end else begin
              owner[k] = -1; cnt[k] = 0;
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    #2;
    for (int k = 0; k < 2; k++) begin
      logic [3:0] eg;
      logic [3:0] ea;
      eg = (owner[k] >= 0) ? 4'(1 << owner[k]) : 4'b0;
      ea = (owner[k] >= 0 && out_ready) ? eg : 4'b0;
      chk($sformatf("m%0d_valid", k), 32'(val_o[k]), 32'(owner[k] >= 0));
      chk($sformatf("m%0d_gnt", k), 32'(gnt_o[k]), 32'(eg));
      chk($sformatf("m%0d_ack", k), 32'(ack_o[k]), 32'(ea));
      chk($sformatf("m%0d_select", k), 32'(sel_o[k]),
          (owner[k] >= 0) ? 32'(owner[k]) : 32'd0);
      chk($sformatf("m%0d_data", k), dat_o[k], mdat[k]);
    end
  end

  int exp_rr [4] = '{3, 4, 1, 2};
  int exp_sv [10] = '{1, 1, 1, 1, 2, 2, 2, 2, 1, 1};

  initial begin
    for (int i = 0; i < 4; i++) s[i] = 32'(i + 1);
    req = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(gnt_o[0]), 32'h0);
    chk("rst_sel", 32'(sel_o[0]), 32'h0);
    chk("rst_valid", 32'(val_o[0]), 32'h0);
    chk("rst_data", dat_o[0], 32'h0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("first_gnt4", 32'(gnt_o[0]), 32'h1);
    chk("first_data4", dat_o[0], 32'h1);
    chk("first_gnt1", 32'(gnt_o[1]), 32'h1);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s[0] = 32'h100 + 32'(i);
      #1;
      chk("stall_data", dat_o[0], 32'h1);
      chk("stall_ack", 32'(ack_o[0]), 32'h0);
    end
    @(negedge clk);
    s[0] = 32'h11; out_ready = 1'b1;
    #1;
    chk("accept_ack4", 32'(ack_o[0]), 32'h1);
    chk("accept_ack1", 32'(ack_o[1]), 32'h1);
    @(negedge clk);
    s[0] = 32'h1;
    #1;
    chk("next_data4", dat_o[0], 32'h11);
    chk("next_data1", dat_o[1], 32'h2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rr_data1", dat_o[1], 32'(exp_rr[i]));
    end

    @(negedge clk); out_ready = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(val_o[0]), 32'h0);
    chk("midrst_gnt", 32'(gnt_o[0]), 32'h0);
    chk("midrst_ack", 32'(ack_o[0]), 32'h0);
    chk("midrst_data", dat_o[0], 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #1;
    chk("restart_gnt", 32'(gnt_o[0]), 32'h1);

    @(negedge clk);
    rst_n = 1'b0; req = 4'b0100; out_ready = 1'b1; s[2] = 32'hA5A5_0001;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    s[2] = 32'hA5A5_0002;
    #1;
    chk("single_sel", 32'(sel_o[0]), 32'h2);
    chk("single_d1", dat_o[0], 32'hA5A5_0001);
    chk("single_ack1", 32'(ack_o[0]), 32'h4);
    @(negedge clk); #1;
    chk("single_d2", dat_o[0], 32'hA5A5_0002);
    chk("single_ack2", 32'(ack_o[0]), 32'h4);

    @(negedge clk);
    rst_n = 1'b0; req = 4'b0011; s[0] = 32'h1; s[1] = 32'h2;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      chk("starve_data", dat_o[0], 32'(exp_sv[i]));
    end

    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      req = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) s[i] = $urandom;
    end

    @(negedge clk); #3;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_mux4_arbiter.md
Name: rr_mux4_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit output channel between four requesters.
- Drives the 2-bit select of the team's 4:1 32-bit source mux (select 0..3 maps to Src1..Src4).
- Registers the selected word and presents it downstream on a valid/ready handshake.
- Sits between the four producer units and the single consumer datapath port.

Parameters:
- WIDTH, 32, data width of each source and of out_data.
- MAX_BEATS, 4, maximum consecutive accepted beats for one requester before a forced rotation. Legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request per source. Bit i corresponds to Src(i+1).
- src1..src4  input  WIDTH each  source data words.
- select  output  2  index of the current owner; drives the mux select.
- gnt  output  4  one-hot current owner; all zero when idle.
- ack  output  4  one-cycle pulse to owner i when its beat is accepted downstream.
- out_valid  output  1  out_data holds a valid beat.
- out_ready  input  1  consumer accepts the beat when high with out_valid.
- out_data  output  WIDTH  registered beat.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, select=0, gnt=0, ack=0, out_valid=0, out_data=0, ptr=0, beat_cnt=0.
- ptr (2b) is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, mod 4 wrap.
- IDLE, no req: remain IDLE, all outputs hold reset values except out_data, which holds its last value.
- IDLE, any req:
  - The winner w is the first set bit in search order.
  - On the same edge: select=w, gnt=onehot(w), out_data=src(w), out_valid=1, beat_cnt=1, state=BUSY.
  - Latency from req rising to out_valid is 1 cycle.
- BUSY, out_ready=0: hold all outputs. out_data stays stable and is not resampled while stalled.
- BUSY, out_ready=1 (beat accepted): ack[select]=1 for exactly this cycle. Then one of three cases applies:
  - Continue: if req[select]=1 and beat_cnt<MAX_BEATS, recapture out_data=src(select), beat_cnt++, stay BUSY with out_valid=1. This gives back-to-back beats with no bubble.
  - Rotate: otherwise ptr=select+1 (wrap 3->0). Re-arbitrate on the same edge using the new ptr and the current req, excluding the releasing index this cycle.
    - If a winner exists, grant it exactly as from IDLE, with no bubble.
    - If none exists, go to IDLE with out_valid=0, gnt=0.
  - Forced rotation at beat_cnt==MAX_BEATS is taken even when req[select] is still high. The releasing requester is reconsidered only on a later arbitration.
- Owner drops req while BUSY before acceptance: the captured beat is committed and still delivered. Release follows the Rotate rule.
- Non-owner req changes while BUSY: no effect until the next arbitration.
- ack is never asserted in IDLE. At most one ack bit is high per cycle.
- gnt is one-hot or zero. select equals the gnt index whenever gnt is nonzero.
- rst_n asserted mid-transfer: immediate return to reset values. The in-flight beat is dropped and no ack is issued.
- beat_cnt width is 4 bits. MAX_BEATS=1 gives pure per-beat round robin.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined: adds input port lock (4 bits).
  - While BUSY with lock[select]=1 and req[select]=1, every accepted beat takes the Continue path regardless of MAX_BEATS. beat_cnt saturates at MAX_BEATS.
  - Dropping lock applies the normal rule at the next accepted beat: forced rotation if beat_cnt>=MAX_BEATS.
- Not defined: no lock port. Rotation is governed by MAX_BEATS only.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111 -> gnt=0, select=0, out_valid=0, out_data=0. Release rst_n -> the next edge gives gnt=4'b0001, out_data=src1.
- Single requester: req=4'b0100, src3=32'hA5A5_0001 then 32'hA5A5_0002, out_ready=1 -> select=2, two beats delivered in consecutive cycles, ack=4'b0100 on each.
- Fairness, MAX_BEATS=1: req=4'b1111 held, src(i)=i+1, out_ready=1 -> out_data sequence 1,2,3,4,1 with no idle cycles.
- Backpressure: owner src1, out_ready=0 for 5 cycles while src1 changes -> out_data stays at its captured value, ack=0. out_ready=1 -> single ack, then the next beat.
- MAX_BEATS=4 starvation guard: req=4'b0011 held, out_ready=1 -> 4 beats from src1, then src2 granted on the same edge, then 4 beats from src2, then src1.
- Reset mid-transfer: BUSY with out_ready=0, pulse rst_n low for 1 cycle -> all outputs at reset values immediately, no ack. After release, arbitration restarts from ptr=0.
